// File: rtl/writeback_stage_p.sv
// Registered writeback: selects ALU / load / link result, formats loads, drives the regfile write port.
// Latency: 1 cycle from acceptance (or from the late memory response) to wb_valid/RegW_en.
// Backpressure: in_ready drops while waiting for a late load response; one instruction per cycle otherwise.
module writeback_stage_p #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LO_W       = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  RegW_en_init,
    input  logic [REG_ADDR_W-1:0] RegD_init,
    input  logic [1:0]            src_sel,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     link_addr,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [LO_W-1:0]       addr_lo,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     memReadVal,
    output logic [DATA_W-1:0]     WriteData,
    output logic [REG_ADDR_W-1:0] RegD,
    output logic                  RegW_en,
    output logic                  wb_valid,
    output logic                  busy,
    output logic [CNT_W-1:0]      retired_count
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                  state_q, state_d;
    logic                    regw_lat_q, regw_lat_d;
    logic [REG_ADDR_W-1:0]   regd_lat_q, regd_lat_d;
    logic [1:0]              ld_size_q, ld_size_d;
    logic                    ld_unsigned_q, ld_unsigned_d;
    logic [LO_W-1:0]         addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]       write_data_q, write_data_d;
    logic [REG_ADDR_W-1:0]   regd_q, regd_d;
    logic                    regw_en_q, regw_en_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0]        retired_count_q, retired_count_d;

    logic [1:0]              fmt_size;
    logic                    fmt_uns;
    logic [LO_W-1:0]         fmt_lo;
    logic [LO_W-1:0]         off_mask;
    logic [LO_W-1:0]         fmt_off;
    logic [DATA_W-1:0]       shifted;
    logic [DATA_W-1:0]       keep_mask;
    logic [DATA_W-1:0]       load_val;
    logic                    sign_bit;

    // Load formatting: shift the addressed lane down to bit 0, then zero/sign-extend it.
    // While waiting, the load descriptor comes from the latched copy, not the (ignored) inputs.
    always_comb begin
        fmt_size  = (state_q == WAIT_MEM) ? ld_size_q     : ld_size;
        fmt_uns   = (state_q == WAIT_MEM) ? ld_unsigned_q : ld_unsigned;
        fmt_lo    = (state_q == WAIT_MEM) ? addr_lo_q     : addr_lo;
        off_mask  = '0;
        keep_mask = '1;
        case (fmt_size)
            2'b00: begin
                off_mask  = '1;
                keep_mask = DATA_W'(8'hFF);
            end
            2'b01: begin
                off_mask  = ~LO_W'(1);
                keep_mask = DATA_W'(16'hFFFF);
            end
            2'b10: begin
                // On a 32-bit datapath the word mask clears every offset bit: pass-through.
                off_mask  = ~LO_W'(3);
                keep_mask = DATA_W'(32'hFFFF_FFFF);
            end
            default: begin
                off_mask  = '0;
                keep_mask = '1;
            end
        endcase
        fmt_off = fmt_lo & off_mask;
        shifted = memReadVal >> {fmt_off, 3'b000};
        case (fmt_size)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
        load_val = (shifted & keep_mask) | ({DATA_W{sign_bit & ~fmt_uns}} & ~keep_mask);
    end

    // Next-state, load-descriptor latch and retirement result selection.
    always_comb begin
        logic                  retire;
        logic [DATA_W-1:0]     res_data;
        logic [REG_ADDR_W-1:0] res_regd;
        logic                  res_wen;

        retire        = 1'b0;
        res_data      = alu_result;
        res_regd      = RegD_init;
        res_wen       = RegW_en_init;
        state_d       = state_q;
        regw_lat_d    = regw_lat_q;
        regd_lat_d    = regd_lat_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        addr_lo_d     = addr_lo_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (src_sel == 2'b01 && !mem_rsp_valid) begin
                        regw_lat_d    = RegW_en_init;
                        regd_lat_d    = RegD_init;
                        ld_size_d     = ld_size;
                        ld_unsigned_d = ld_unsigned;
                        addr_lo_d     = addr_lo;
                        state_d       = WAIT_MEM;
                    end else begin
                        retire = 1'b1;
                        case (src_sel)
                            2'b01:   res_data = load_val;
                            2'b10:   res_data = link_addr;
                            default: res_data = alu_result;
                        endcase
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    retire   = 1'b1;
                    res_data = load_val;
                    res_regd = regd_lat_q;
                    res_wen  = regw_lat_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wb_valid_d      = retire;
        regw_en_d       = retire & res_wen & (res_regd != '0);
        write_data_d    = retire ? res_data : write_data_q;
        regd_d          = retire ? res_regd : regd_q;
        retired_count_d = retired_count_q + CNT_W'(retire);
    end

    // State, latched descriptor and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            regw_lat_q      <= 1'b0;
            regd_lat_q      <= '0;
            ld_size_q       <= '0;
            ld_unsigned_q   <= 1'b0;
            addr_lo_q       <= '0;
            write_data_q    <= '0;
            regd_q          <= '0;
            regw_en_q       <= 1'b0;
            wb_valid_q      <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            regw_lat_q      <= regw_lat_d;
            regd_lat_q      <= regd_lat_d;
            ld_size_q       <= ld_size_d;
            ld_unsigned_q   <= ld_unsigned_d;
            addr_lo_q       <= addr_lo_d;
            write_data_q    <= write_data_d;
            regd_q          <= regd_d;
            regw_en_q       <= regw_en_d;
            wb_valid_q      <= wb_valid_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q == WAIT_MEM);
    assign WriteData     = write_data_q;
    assign RegD          = regd_q;
    assign RegW_en       = regw_en_q;
    assign wb_valid      = wb_valid_q;
    assign retired_count = retired_count_q;

endmodule

// File: doc/writeback_stage_p.md
Name: writeback_stage_p

Overview:
Parametrised, registered writeback stage. It is the successor to the combinational ALU/memory writeback mux.
- Selects one of three result sources: ALU, load data, or link address.
- Aligns and sign/zero-extends load data.
- Waits for late memory responses using a small FSM with a ready/valid handshake to the MEM stage.
- Drives the register-file write port one cycle after the result is available, and counts retired instructions.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64
REG_ADDR_W, 5, register index width
LO_W, 2, byte-offset width; must equal log2(DATA_W/8)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept an instruction
RegW_en_init  input  1  instruction writes a register
RegD_init  input  REG_ADDR_W  destination register
src_sel  input  2  00 ALU, 01 MEM, 10 LINK, 11 treated as ALU
alu_result  input  DATA_W  ALU result
link_addr  input  DATA_W  return address (PC+4)
ld_size  input  2  00 byte, 01 half, 10 word, 11 double (word when DATA_W=32)
ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend
addr_lo  input  LO_W  low bits of load address
mem_rsp_valid  input  1  memReadVal is valid this cycle
memReadVal  input  DATA_W  raw memory read word
WriteData  output  DATA_W  register write data
RegD  output  REG_ADDR_W  register write index
RegW_en  output  1  register write strobe
wb_valid  output  1  one instruction retired this cycle
busy  output  1  FSM in WAIT_MEM
retired_count  output  CNT_W  retired-instruction counter

Behaviour:
- Reset (reset=0, async):
  - State becomes IDLE.
  - WriteData, RegD, RegW_en, wb_valid, retired_count all go to 0.
  - Any pending load is discarded. A mem_rsp_valid arriving after reset is ignored.
- States IDLE and WAIT_MEM:
  - in_ready = (state==IDLE).
  - busy = (state==WAIT_MEM).
- IDLE, in_valid=1, src_sel!=01: capture the instruction. On the next edge:
  - WriteData = alu_result (00/11) or link_addr (10).
  - RegD = RegD_init.
  - wb_valid = 1.
  - Latency 1 cycle.
- IDLE, in_valid=1, src_sel=01, mem_rsp_valid=1 in the same cycle: complete as above with the formatted load value. Latency 1.
- IDLE, in_valid=1, src_sel=01, mem_rsp_valid=0:
  - Latch RegW_en_init, RegD_init, ld_size, ld_unsigned, addr_lo.
  - Go to WAIT_MEM.
- WAIT_MEM:
  - in_ready=0, so inputs other than mem_rsp_valid/memReadVal are ignored.
  - On mem_rsp_valid=1: outputs update at the next edge from the latched fields and the formatted memReadVal, and the state returns to IDLE.
  - A new instruction is accepted no earlier than the cycle after that return.
- IDLE with mem_rsp_valid=1 and no MEM instruction: ignored.
- Load formatting:
  - Byte lane = addr_lo.
  - Half lane = addr_lo[LO_W-1:1]; addr_lo[0] is ignored for half.
  - Word lane = addr_lo[LO_W-1:2] (64-bit only).
  - The selected field is extended to DATA_W: zero-extended if ld_unsigned=1, else sign-extended.
  - Word with DATA_W=32, or double, passes through unmodified.
- RegW_en = wb_valid AND latched RegW_en_init AND (RegD != 0). Writes to register 0 are suppressed, but the instruction still retires.
- RegW_en and wb_valid are single-cycle pulses per retired instruction. WriteData and RegD hold their last value between retirements.
- Throughput: one instruction per cycle for non-stalling instructions, back to back.
- retired_count increments by 1 on every wb_valid cycle and wraps modulo 2^CNT_W.
- All outputs are registered. No combinational path exists from inputs to WriteData, RegD or RegW_en.

Test Plan:
- Reset held low for 3 cycles, then released:
  - All outputs are 0 and in_ready=1.
  - Asserting reset=0 mid-WAIT_MEM returns busy=0 and produces no wb_valid.
- Back-to-back ALU instructions:
  - Stimulus: RegD 5/6, alu_result 0x11/0x22 on consecutive cycles.
  - Response: WriteData 0x11 then 0x22 on consecutive cycles, RegW_en=1 both cycles, retired_count=2.
- Load byte, addr_lo=3, memReadVal=0x80FF_1234, response in the same cycle:
  - Signed: WriteData=0xFFFF_FF80.
  - ld_unsigned=1: WriteData=0x0000_0080.
  - Half, addr_lo=2, signed: WriteData=0xFFFF_80FF.
- Late load:
  - Stimulus: src_sel=01, mem_rsp_valid held 0 for 4 cycles, then 1 with memReadVal=0x1234_5678, word.
  - Response: in_ready=0 and busy=1 for those 4 cycles; wb_valid one cycle after the response with WriteData=0x1234_5678; in_ready=1 the cycle after.
- Register-0 write:
  - Stimulus: RegW_en_init=1, RegD_init=0, alu_result=0xDEAD_BEEF.
  - Response: wb_valid=1, RegW_en=0, retired_count increments.
- Link and wrap:
  - Stimulus: src_sel=10, link_addr=0x0000_0104.
  - Response: WriteData=0x0000_0104.
  - With CNT_W=4, 17 retirements give retired_count=1.
